// File: rtl/mac_out_collector_pkg.sv
// Shared types and constants for the MAC output collector: FSM states,
// output-mode encodings and the MAC result width.
package mac_out_collector_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [1:0] OP_BINARIZE = 2'b00;
  localparam logic [1:0] OP_RAW      = 2'b01;

  localparam int MAC_OUT_W = 5;

  // Only the raw code selects raw sums; every other encoding binarizes.
  function automatic logic is_raw_op(input logic [1:0] op);
    return op == OP_RAW;
  endfunction

endpackage

// File: rtl/mac_out_word_fifo.sv
// Two-entry synchronous word FIFO. Accepts a push while full when a pop
// happens in the same cycle; otherwise a push into a full FIFO is ignored.
module mac_out_word_fifo #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [WORD_WIDTH-1:0] mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset on purpose: the head entry drives out_word
      // directly and must read 0 after reset, and two words are cheap to clear.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // When full with push and pop together, wr_ptr equals rd_ptr: the slot
      // being vacated by the pop is exactly the one the new word lands in.
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_out_collector.sv
// Accumulates MAC popcounts across input channels per output pixel, then packs
// binarized pixel bits into words or emits raw sums through a 2-entry buffer.
module mac_out_collector
  import mac_out_collector_pkg::*;
#(
  parameter int ACC_WIDTH  = 12,
  parameter int WORD_WIDTH = 32,
  parameter int CH_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            operation,
  input  logic [CH_WIDTH-1:0]   cfg_in_channels,
  input  logic [ACC_WIDTH-1:0]  cfg_threshold,
  input  logic [MAC_OUT_W-1:0]  mac_out_in,
  input  logic                  mac_valid,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  sat_err,
  output logic                  overrun
);

  localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

  // Registered state and latched configuration
  state_t                state;
  logic                  raw_mode;
  logic [CH_WIDTH-1:0]   ch_last;
  logic [ACC_WIDTH-1:0]  threshold;
  logic [ACC_WIDTH-1:0]  acc;
  logic [CH_WIDTH-1:0]   ch_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] pack;

  // Next-value datapath
  logic [ACC_WIDTH:0]    acc_sum;
  logic                  sat_hit;
  logic [ACC_WIDTH-1:0]  acc_n;
  logic                  accum_cycle;
  logic                  mac_fire;
  logic                  pixel_done;
  logic                  pixel_bit;
  logic                  word_done;
  logic [WORD_WIDTH-1:0] pack_nx;
  logic [BIT_W-1:0]      bit_nx;
  logic                  push;
  logic [WORD_WIDTH-1:0] push_data;

  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign busy      = (state == ST_ACCUM);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    acc_sum     = {1'b0, acc} + (ACC_WIDTH + 1)'(mac_out_in);
    sat_hit     = acc_sum[ACC_WIDTH];
    acc_n       = sat_hit ? '1 : acc_sum[ACC_WIDTH-1:0];
    accum_cycle = (state == ST_ACCUM) && !start;
    mac_fire    = accum_cycle && mac_valid;
    pixel_done  = mac_fire && (ch_cnt == ch_last);
    pixel_bit   = (acc_n >= threshold);
    word_done   = pixel_done && !raw_mode && (bit_cnt == BIT_LAST);

    pack_nx = pack;
    bit_nx  = bit_cnt;
    if (pixel_done && !raw_mode) begin
      pack_nx = pack | (WORD_WIDTH'(pixel_bit) << bit_cnt);
      bit_nx  = word_done ? '0 : bit_cnt + BIT_W'(1);
    end

    // A coincident mac_valid is applied before flush, so flush sees the
    // updated bit count and packs the bit that mac_valid just produced.
    push      = 1'b0;
    push_data = pack_nx;
    if (pixel_done && raw_mode) begin
      push      = 1'b1;
      push_data = WORD_WIDTH'(acc_n);
    end else if (word_done) begin
      push = 1'b1;
    end else if (accum_cycle && flush && (bit_nx != '0)) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this clock edge.
      state     <= ST_IDLE;
      raw_mode  <= 1'b0;
      ch_last   <= '0;
      threshold <= '0;
      acc       <= '0;
      ch_cnt    <= '0;
      bit_cnt   <= '0;
      pack      <= '0;
      sat_err   <= 1'b0;
      overrun   <= 1'b0;
    end else if (start) begin
      raw_mode  <= is_raw_op(operation);
      ch_last   <= (cfg_in_channels == '0) ? '0 : cfg_in_channels - CH_WIDTH'(1);
      threshold <= cfg_threshold;
      acc       <= '0;
      ch_cnt    <= '0;
      bit_cnt   <= '0;
      pack      <= '0;
      sat_err   <= 1'b0;
      overrun   <= 1'b0;
      state     <= ST_ACCUM;
    end else if (state == ST_ACCUM) begin
      if (mac_valid) begin
        if (sat_hit) begin
          sat_err <= 1'b1;
        end
        if (pixel_done) begin
          acc    <= '0;
          ch_cnt <= '0;
        end else begin
          acc    <= acc_n;
          ch_cnt <= ch_cnt + CH_WIDTH'(1);
        end
      end
      bit_cnt <= bit_nx;
      pack    <= word_done ? '0 : pack_nx;
      if (push && fifo_full && !pop) begin
        overrun <= 1'b1;
      end
      // Flush discards the partial pixel and packed bits after they were pushed.
      if (flush) begin
        acc     <= '0;
        ch_cnt  <= '0;
        bit_cnt <= '0;
        pack    <= '0;
        state   <= ST_IDLE;
      end
    end
  end

  mac_out_word_fifo #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (out_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mac_out_collector.sv
// Self-checking bench for mac_out_collector: a pixel-level reference model
// feeds an expected-word queue that a negedge monitor drains and compares.
module tb_mac_out_collector;

  localparam int ACC_WIDTH  = 12;
  localparam int WORD_WIDTH = 32;
  localparam int CH_WIDTH   = 8;
  localparam int ACC_MAX    = (1 << ACC_WIDTH) - 1;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  flush;
  logic [1:0]            operation;
  logic [CH_WIDTH-1:0]   cfg_in_channels;
  logic [ACC_WIDTH-1:0]  cfg_threshold;
  logic [4:0]            mac_out_in;
  logic                  mac_valid;
  logic [WORD_WIDTH-1:0] out_word;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  sat_err;
  logic                  overrun;

  mac_out_collector #(
    .ACC_WIDTH  (ACC_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .CH_WIDTH   (CH_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .flush           (flush),
    .operation       (operation),
    .cfg_in_channels (cfg_in_channels),
    .cfg_threshold   (cfg_threshold),
    .mac_out_in      (mac_out_in),
    .mac_valid       (mac_valid),
    .out_word        (out_word),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .sat_err         (sat_err),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: works on whole pixels (running channel sum, list of bits)
  logic [31:0] exp_q[$];
  int          m_ch, m_thr, m_sum, m_cnt, m_held;
  bit          m_raw, m_sat, m_stalled;
  bit          m_bits[$];
  bit          rnd_ready;

  function automatic void model_push(input logic [31:0] w);
    // While the consumer is stalled, only two words fit; later ones are lost.
    if (m_stalled && m_held >= 2) return;
    exp_q.push_back(w);
    if (m_stalled) m_held++;
  endfunction

  function automatic void model_pack();
    logic [31:0] w;
    w = '0;
    foreach (m_bits[i]) w[i] = m_bits[i];
    model_push(w);
    m_bits.delete();
  endfunction

  function automatic void model_start(input int op, input int ch, input int thr);
    m_raw = (op == 1);
    m_ch  = (ch == 0) ? 1 : ch;
    m_thr = thr;
    m_sum = 0;
    m_cnt = 0;
    m_sat = 0;
    m_bits.delete();
  endfunction

  function automatic void model_mac(input int v);
    int pix;
    m_sum += v;
    if (m_sum > ACC_MAX) m_sat = 1;
    m_cnt++;
    if (m_cnt == m_ch) begin
      pix   = (m_sum > ACC_MAX) ? ACC_MAX : m_sum;
      m_sum = 0;
      m_cnt = 0;
      if (m_raw) model_push(32'(pix));
      else begin
        m_bits.push_back(pix >= m_thr);
        if (m_bits.size() == WORD_WIDTH) model_pack();
      end
    end
  endfunction

  function automatic void model_flush();
    if (m_bits.size() > 0) model_pack();
    m_sum = 0;
    m_cnt = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start(input int op, input int ch, input int thr);
    operation       = 2'(op);
    cfg_in_channels = CH_WIDTH'(ch);
    cfg_threshold   = ACC_WIDTH'(thr);
    start           = 1'b1;
    model_start(op, ch, thr);
    step();
    start = 1'b0;
  endtask

  task automatic do_mac(input int v, input bit fl);
    mac_valid  = 1'b1;
    mac_out_in = 5'(v);
    flush      = fl;
    model_mac(v);
    if (fl) model_flush();
    step();
    mac_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      step();
      n++;
    end
    check(name, 32'(n < 500), 32'd1);
  endtask

  // Monitor: one pop per cycle, checked mid-cycle while out_ready is stable
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=0x%08h expected=none", out_word);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_word", out_word, mon_exp);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[$];
    int nmac, op, ch, thr, seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; operation = '0;
    cfg_in_channels = '0; cfg_threshold = '0; mac_out_in = '0; mac_valid = 1'b0;
    out_ready = 1'b1; rnd_ready = 1'b0; m_stalled = 0; m_held = 0;
    model_start(0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat_err", 32'(sat_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Binarize, full word: 21 vs 6 alternating against threshold 20
    do_start(0, 3, 20);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    for (int p = 0; p < 32; p++) begin
      vals = (p % 2 == 0) ? '{10, 5, 6} : '{1, 2, 3};
      for (int c = 0; c < 3; c++) begin
        do_mac(vals[c], 1'b0);
        if (p == 31 && c == 1) check("t1_no_early_valid", 32'(out_valid), 32'd0);
      end
    end
    check("t1_valid_latency", 32'(out_valid), 32'd1);
    check("t1_word_head", out_word, 32'h5555_5555);
    wait_drain("t1_drain");
    check("t1_sat_err", 32'(sat_err), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);
    do_flush();
    check("t1_idle_after_flush", 32'(busy), 32'd0);

    // Raw mode: pairs summed and emitted in order
    do_start(1, 2, 0);
    do_mac(25, 1'b0); do_mac(25, 1'b0);
    do_mac(0, 1'b0);  do_mac(7, 1'b0);
    wait_drain("t2_drain");
    do_flush();

    // Saturation: 255 x 25 clamps to the accumulator maximum
    do_start(1, 255, 0);
    for (int i = 0; i < 255; i++) do_mac(25, 1'b0);
    wait_drain("t3_drain");
    check("t3_sat_err", 32'(sat_err), 32'd1);
    do_flush();
    repeat (4) step();
    check("t3_sat_sticky", 32'(sat_err), 32'd1);

    // Backpressure and overrun: third word is dropped
    out_ready = 1'b0; m_stalled = 1; m_held = 0;
    do_start(1, 1, 0);
    check("t3_sat_cleared_by_start", 32'(sat_err), 32'd0);
    do_mac(5, 1'b0); do_mac(9, 1'b0); do_mac(13, 1'b0);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_head_word", out_word, 32'd5);
    out_ready = 1'b1; m_stalled = 0;
    wait_drain("t4_drain");
    check("t4_empty_after_drain", 32'(out_valid), 32'd0);
    do_flush();

    // Partial flush, separate and coincident with the last mac_valid
    do_start(0, 1, 1);
    do_mac(1, 1'b0); do_mac(0, 1'b0); do_mac(1, 1'b0); do_mac(1, 1'b0); do_mac(0, 1'b0);
    do_flush();
    check("t5_busy_after_flush", 32'(busy), 32'd0);
    check("t5_flush_word", out_word, 32'h0000_000D);
    wait_drain("t5_drain_a");
    do_start(0, 1, 1);
    do_mac(1, 1'b0); do_mac(0, 1'b0); do_mac(1, 1'b0); do_mac(1, 1'b0);
    do_mac(0, 1'b1);
    check("t5_busy_after_coincident", 32'(busy), 32'd0);
    check("t5_coincident_word", out_word, 32'h0000_000D);
    wait_drain("t5_drain_b");

    // Randomized rounds against the model
    for (int r = 0; r < 30; r++) begin
      op  = $urandom_range(0, 3);
      ch  = ($urandom_range(0, 4) == 0) ? $urandom_range(7, 255) : $urandom_range(0, 6);
      thr = $urandom_range(0, 160);
      rnd_ready = (op != 1);
      do_start(op, ch, thr);
      nmac = $urandom_range(1, 120);
      for (int i = 0; i < nmac - 1; i++) begin
        if ($urandom_range(0, 3) == 0) step();
        if ($urandom_range(0, 40) == 0) do_start(op, ch, thr);
        do_mac($urandom_range(0, 25), 1'b0);
      end
      if ($urandom_range(0, 1) == 1) do_mac($urandom_range(0, 25), 1'b1);
      else begin
        do_mac($urandom_range(0, 25), 1'b0);
        do_flush();
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      wait_drain("rnd_drain");
      check("rnd_sat_err", 32'(sat_err), 32'(m_sat));
      check("rnd_overrun", 32'(overrun), 32'd0);
      check("rnd_busy", 32'(busy), 32'd0);
    end

    // Reset mid-operation with one word buffered
    out_ready = 1'b0; m_stalled = 1; m_held = 0;
    do_start(1, 2, 0);
    do_mac(4, 1'b0); do_mac(4, 1'b0); do_mac(1, 1'b0);
    check("t6_buffered_word", out_word, 32'd8);
    rst = 1'b1;
    step();
    check("t6_rst_out_word", out_word, 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_sat_err", 32'(sat_err), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_stalled = 0;
    out_ready = 1'b1;
    seen = 0;
    mac_valid = 1'b1; mac_out_in = 5'd25;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid || busy) seen++;
    end
    mac_valid = 1'b0;
    check("t6_idle_ignores_mac", 32'(seen), 32'd0);

    // Restart during ACCUM discards the partial word
    do_start(0, 1, 1);
    do_mac(1, 1'b0); do_mac(1, 1'b0); do_mac(1, 1'b0);
    do_start(0, 1, 1);
    do_flush();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("t6_restart_no_push", 32'(seen), 32'd0);
    check("t6_restart_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
